// File: rtl/bus_arbiter.sv
// ----------------------------------------------------------------------------
// bus_arbiter
//
// Round-robin arbiter that shares one external memory bus between
// N_MASTERS bus masters. One master is granted at a time and keeps the grant
// until the slave acknowledges or the watchdog aborts the transaction.
//
// Parameters
//   N_MASTERS  number of requesters (2..8)
//   TIMEOUT    BUSY cycles allowed without i_ack before abort; 0 = never
//
// Ports
//   i_clk, i_rst   clock, asynchronous active-high reset
//   i_m_bus_en     per-master request (bit k = master k)
//   i_m_wr_en      per-master write flag
//   i_m_addr       per-master address, master k in [32k+31:32k]
//   i_m_wr_data    per-master write data, same packing
//   i_m_byte_en    per-master byte enables, master k in [4k+3:4k]
//   o_m_ack        one-cycle completion pulse to the granted master
//   o_m_err        one-cycle timeout-abort pulse to the granted master
//   o_m_rd_data    read data broadcast, valid only with o_m_ack
//   i_ack          slave completion
//   i_rd_data      slave read data, valid with i_ack
//   o_bus_en       bus request (high for the whole BUSY phase)
//   o_wr_en        bus write flag
//   o_addr         bus address
//   o_wr_data      bus write data
//   o_byte_en      bus byte enables
// ----------------------------------------------------------------------------
module bus_arbiter #(
    parameter int N_MASTERS = 2,
    parameter int TIMEOUT   = 255
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [N_MASTERS-1:0]      i_m_bus_en,
    input  logic [N_MASTERS-1:0]      i_m_wr_en,
    input  logic [32*N_MASTERS-1:0]   i_m_addr,
    input  logic [32*N_MASTERS-1:0]   i_m_wr_data,
    input  logic [4*N_MASTERS-1:0]    i_m_byte_en,
    output logic [N_MASTERS-1:0]      o_m_ack,
    output logic [N_MASTERS-1:0]      o_m_err,
    output logic [31:0]               o_m_rd_data,
    input  logic                      i_ack,
    input  logic [31:0]               i_rd_data,
    output logic                      o_bus_en,
    output logic                      o_wr_en,
    output logic [31:0]               o_addr,
    output logic [31:0]               o_wr_data,
    output logic [3:0]                o_byte_en
);

    localparam int GW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    // The counter holds the number of BUSY cycles already completed, so the
    // abort fires in the cycle where it equals TIMEOUT-1 (the TIMEOUT-th cycle).
    localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : {CW{1'b0}};
    localparam logic [CW-1:0] CNT_SAT  = {CW{1'b1}};

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t         state_r,      state_nxt_s;
    logic [GW-1:0]  grant_r,      grant_nxt_s;
    logic [GW-1:0]  last_grant_r, last_grant_nxt_s;
    logic [CW-1:0]  wdog_r,       wdog_nxt_s;

    logic           hi_found_s, lo_found_s;
    logic [GW-1:0]  hi_idx_s,   lo_idx_s;
    logic           pick_valid_s;
    logic [GW-1:0]  pick_idx_s;
    logic           ack_fire_s;
    logic           to_fire_s;

    // Round-robin pick: lowest requester above last_grant, else lowest at or below it.
    always_comb begin
        hi_found_s = 1'b0;
        lo_found_s = 1'b0;
        hi_idx_s   = {GW{1'b0}};
        lo_idx_s   = {GW{1'b0}};
        // Descending scan so the last overwrite leaves the lowest index.
        for (int k = N_MASTERS - 1; k >= 0; k--) begin
            if (i_m_bus_en[k]) begin
                if (GW'(k) > last_grant_r) begin
                    hi_found_s = 1'b1;
                    hi_idx_s   = GW'(k);
                end else begin
                    lo_found_s = 1'b1;
                    lo_idx_s   = GW'(k);
                end
            end else begin
                hi_found_s = hi_found_s;
            end
        end
        pick_valid_s = hi_found_s | lo_found_s;
        pick_idx_s   = hi_found_s ? hi_idx_s : lo_idx_s;
    end

    // Completion / abort decode; an ack in the timeout cycle suppresses the abort.
    always_comb begin
        ack_fire_s = (state_r == BUSY) && i_ack;
        to_fire_s  = (state_r == BUSY) && !i_ack && (TIMEOUT != 0) && (wdog_r == CNT_LAST);
    end

    // Next-state logic for the IDLE/BUSY controller, grant and watchdog.
    always_comb begin
        state_nxt_s      = state_r;
        grant_nxt_s      = grant_r;
        last_grant_nxt_s = last_grant_r;
        wdog_nxt_s       = wdog_r;
        case (state_r)
            IDLE: begin
                if (pick_valid_s) begin
                    state_nxt_s = BUSY;
                    grant_nxt_s = pick_idx_s;
                    wdog_nxt_s  = {CW{1'b0}};
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            BUSY: begin
                if (ack_fire_s || to_fire_s) begin
                    state_nxt_s      = IDLE;
                    last_grant_nxt_s = grant_r;
                    wdog_nxt_s       = {CW{1'b0}};
                end else if (wdog_r != CNT_SAT) begin
                    wdog_nxt_s = wdog_r + CW'(1'b1);
                end else begin
                    wdog_nxt_s = wdog_r;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State registers; reset gives master 0 first priority.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_r      <= IDLE;
            grant_r      <= {GW{1'b0}};
            last_grant_r <= GW'(N_MASTERS - 1);
            wdog_r       <= {CW{1'b0}};
        end else begin
            state_r      <= state_nxt_s;
            grant_r      <= grant_nxt_s;
            last_grant_r <= last_grant_nxt_s;
            wdog_r       <= wdog_nxt_s;
        end
    end

    // Bus payload mux and per-master response routing; everything is 0 in IDLE.
    always_comb begin
        o_bus_en    = 1'b0;
        o_wr_en     = 1'b0;
        o_addr      = 32'h0000_0000;
        o_wr_data   = 32'h0000_0000;
        o_byte_en   = 4'b0000;
        o_m_rd_data = 32'h0000_0000;
        o_m_ack     = {N_MASTERS{1'b0}};
        o_m_err     = {N_MASTERS{1'b0}};
        if (state_r == BUSY) begin
            o_bus_en = 1'b1;
            for (int k = 0; k < N_MASTERS; k++) begin
                if (grant_r == GW'(k)) begin
                    o_wr_en    = i_m_wr_en[k];
                    o_addr     = i_m_addr[32*k +: 32];
                    o_wr_data  = i_m_wr_data[32*k +: 32];
                    o_byte_en  = i_m_byte_en[4*k +: 4];
                    o_m_ack[k] = ack_fire_s;
                    o_m_err[k] = to_fire_s;
                end else begin
                    o_m_ack[k] = 1'b0;
                end
            end
            o_m_rd_data = ack_fire_s ? i_rd_data : 32'h0000_0000;
        end else begin
            o_bus_en = 1'b0;
        end
    end

endmodule
